// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU and the multiply/divide unit.
package alu_pkg;

  localparam int unsigned ALUCTR_W = 4;
  localparam int unsigned MDOP_W   = 3;

  typedef enum logic [ALUCTR_W-1:0] {
    ALU_ADDU = 4'd0,
    ALU_SUBU = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_LUI  = 4'd8,
    ALU_SLL  = 4'd9,
    ALU_SRL  = 4'd10,
    ALU_SRA  = 4'd11,
    ALU_SLLV = 4'd12,
    ALU_SRLV = 4'd13,
    ALU_SRAV = 4'd14
  } alu_op_e;

  typedef enum logic [MDOP_W-1:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle ALU datapath: arithmetic, logic, shifts and compare flags.
module alu_comb
  import alu_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0]         a,
  input  logic [W-1:0]         b,
  input  logic [3:0]           aluctr,
  input  logic [$clog2(W)-1:0] shamt,
  output logic [W-1:0]         aluout,
  output logic                 equal,
  output logic                 less,
  output logic                 less_s
);

  localparam int unsigned SW = $clog2(W);

  logic [SW-1:0] vsh;

  assign vsh    = a[SW-1:0];
  assign equal  = (a == b);
  assign less   = (a < b);
  assign less_s = ($signed(a) < $signed(b));

  always_comb begin
    aluout = '0;
    case (aluctr)
      ALU_ADDU: aluout = a + b;
      ALU_SUBU: aluout = a - b;
      ALU_AND:  aluout = a & b;
      ALU_OR:   aluout = a | b;
      ALU_XOR:  aluout = a ^ b;
      ALU_NOR:  aluout = ~(a | b);
      ALU_SLT:  aluout = {{(W-1){1'b0}}, less_s};
      ALU_SLTU: aluout = {{(W-1){1'b0}}, less};
      ALU_LUI:  aluout = b << (W/2);
      ALU_SLL:  aluout = b << shamt;
      ALU_SRL:  aluout = b >> shamt;
      ALU_SRA:  aluout = $signed(b) >>> shamt;
      ALU_SLLV: aluout = b << vsh;
      ALU_SRLV: aluout = b >> vsh;
      ALU_SRAV: aluout = $signed(b) >>> vsh;
      default:  aluout = '0;
    endcase
  end

endmodule

// File: rtl/alu_md_unit.sv
// EX-stage ALU plus fixed-latency multiply/divide unit with HI/LO registers.
// Define MD_SIGNED_EN to make MULT/DIV two's-complement; otherwise they run unsigned.
module alu_md_unit
  import alu_pkg::*;
#(
  parameter int unsigned W          = 32,
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [W-1:0]         a,
  input  logic [W-1:0]         b,
  input  logic [3:0]           aluctr,
  input  logic [$clog2(W)-1:0] shamt,
  output logic [W-1:0]         aluout,
  output logic                 equal,
  output logic                 less,
  output logic                 less_s,
  input  logic [2:0]           md_op,
  input  logic                 md_start,
  output logic                 busy,
  output logic [W-1:0]         hi,
  output logic [W-1:0]         lo
);

  localparam int unsigned MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  alu_comb #(.W(W)) u_comb (
    .a      (a),
    .b      (b),
    .aluctr (aluctr),
    .shamt  (shamt),
    .aluout (aluout),
    .equal  (equal),
    .less   (less),
    .less_s (less_s)
  );

  md_state_e      state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [W-1:0]   hi_pend, lo_pend, hi_pend_nxt, lo_pend_nxt;
  logic [W-1:0]   hi_nxt, lo_nxt;

  logic           sgn, a_neg, b_neg;
  logic [2*W-1:0] ax, bx, prod;
  logic [W-1:0]   am, bm, qm, rm;
  logic [W-1:0]   md_hi, md_lo;

  // Operand sign handling: signed ops work on magnitudes, then fix result signs
  always_comb begin
`ifdef MD_SIGNED_EN
    sgn = (md_op == MD_MULT) || (md_op == MD_DIV);
`else
    sgn = 1'b0;
`endif
    a_neg = sgn & a[W-1];
    b_neg = sgn & b[W-1];
  end

  assign ax   = {{W{a_neg}}, a};
  assign bx   = {{W{b_neg}}, b};
  assign prod = ax * bx;
  assign am   = a_neg ? -a : a;
  assign bm   = b_neg ? -b : b;
  assign qm   = (bm == '0) ? '0 : am / bm;
  assign rm   = (bm == '0) ? '0 : am % bm;

  // MIN / -1 falls out naturally: |MIN| / 1 re-negated wraps back to MIN, remainder 0
  always_comb begin
    md_hi = prod[2*W-1:W];
    md_lo = prod[W-1:0];
    if ((md_op == MD_DIV) || (md_op == MD_DIVU)) begin
      if (b == '0) begin
        md_lo = '1;
        md_hi = a;
      end else begin
        md_lo = (a_neg ^ b_neg) ? -qm : qm;
        md_hi = a_neg ? -rm : rm;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      hi_pend <= '0;
      lo_pend <= '0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      hi_pend <= hi_pend_nxt;
      lo_pend <= lo_pend_nxt;
      hi      <= hi_nxt;
      lo      <= lo_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    hi_pend_nxt = hi_pend;
    lo_pend_nxt = lo_pend;
    hi_nxt      = hi;
    lo_nxt      = lo;
    case (state)
      ST_IDLE: begin
        if (md_start) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              state_nxt   = ST_BUSY;
              cnt_nxt     = CW'(MUL_CYCLES - 1);
              hi_pend_nxt = md_hi;
              lo_pend_nxt = md_lo;
            end
            MD_DIV, MD_DIVU: begin
              state_nxt   = ST_BUSY;
              cnt_nxt     = CW'(DIV_CYCLES - 1);
              hi_pend_nxt = md_hi;
              lo_pend_nxt = md_lo;
            end
            MD_MTHI: hi_nxt = a;
            MD_MTLO: lo_nxt = a;
            default: ;
          endcase
        end
      end
      ST_BUSY: begin
        if (cnt == '0) begin
          hi_nxt    = hi_pend;
          lo_nxt    = lo_pend;
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
    endcase
  end

  assign busy = (state == ST_BUSY);

endmodule
